// File: rtl/wiegand_tx_sched.sv
// Round-robin scheduler feeding Wiegand_Out: captures a 24-bit payload, adds parity and paces
// the active-low en through a frame plus a gap. Optional macro WIEGAND_REPEAT_EN sends each frame twice.
module wiegand_tx_sched #(
   parameter int unsigned FRAME_CYCLES = 77200,
   parameter int unsigned GAP_CYCLES   = 1000,
   parameter int unsigned CNT_W        = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [23:0] data_a,
   output logic        ack_a,
   input  logic        req_b,
   input  logic [23:0] data_b,
   output logic        ack_b,
   output logic [25:0] wg_data,
   output logic        wg_en,
   output logic        busy,
   output logic        done,
   output logic        src
);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             last_b_q;   // 1 when B holds the most recent grant
`ifdef WIEGAND_REPEAT_EN
   logic             second_q;
`endif

   logic             grant_b;
   logic [23:0]      payload;

   function automatic logic [25:0] build_frame(input logic [23:0] p);
      return {^p[23:12], p, ~(^p[11:0])};
   endfunction

   always_comb begin
      grant_b = req_b & (~req_a | ~last_b_q);
      payload = grant_b ? data_b : data_a;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         last_b_q <= 1'b1;
         wg_en    <= 1'b1;
         wg_data  <= '0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         src      <= 1'b0;
`ifdef WIEGAND_REPEAT_EN
         second_q <= 1'b0;
`endif
      end else begin
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         done  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_a | req_b) begin
                  ack_a    <= ~grant_b;
                  ack_b    <= grant_b;
                  src      <= grant_b;
                  last_b_q <= grant_b;
                  wg_data  <= build_frame(payload);
                  wg_en    <= 1'b0;
                  busy     <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= StSend;
`ifdef WIEGAND_REPEAT_EN
                  second_q <= 1'b0;
`endif
               end
            end
            StSend: begin
               if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
                  wg_en   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StGap;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StGap: begin
               if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt_q <= '0;
`ifdef WIEGAND_REPEAT_EN
                  if (!second_q) begin
                     second_q <= 1'b1;
                     wg_en    <= 1'b0;
                     state_q  <= StSend;
                  end else begin
`else
                  begin
`endif
                     state_q <= StIdle;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_wiegand_tx_sched.sv
// Bench for wiegand_tx_sched: directed known-answer frames, reset abort, then random requesters
// checked every cycle against a time-based reference model (honours WIEGAND_REPEAT_EN).
module tb_wiegand_tx_sched;
   localparam int F  = 20;
   localparam int G  = 5;
   localparam int FG = F + G;
`ifdef WIEGAND_REPEAT_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int TOTAL = PASSES * FG;
   localparam int NCYC  = 3500;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [23:0] data_a = '0, data_b = '0;
   logic        ack_a, ack_b, wg_en, busy, done, src;
   logic [25:0] wg_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   bit          m_active;
   int          m_g;
   logic        m_last_b, m_src, m_ack_a, m_ack_b, m_done, m_busy, m_wg_en;
   logic [25:0] m_wg_data;

   wiegand_tx_sched #(
      .FRAME_CYCLES(F),
      .GAP_CYCLES  (G),
      .CNT_W       (17)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_a  (req_a),
      .data_a (data_a),
      .ack_a  (ack_a),
      .req_b  (req_b),
      .data_b (data_b),
      .ack_b  (ack_b),
      .wg_data(wg_data),
      .wg_en  (wg_en),
      .busy   (busy),
      .done   (done),
      .src    (src)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Leading bit makes upper 12 bits even, trailing bit makes lower 12 bits odd.
   function automatic logic [25:0] wg_frame(input logic [23:0] p);
      logic pe, po;
      pe = ($countones(p[23:12]) % 2) == 1;
      po = ($countones(p[11:0]) % 2) == 0;
      return {pe, p, po};
   endfunction

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      int   r;
      logic gb;
      m_ack_a = 1'b0;
      m_ack_b = 1'b0;
      m_done  = 1'b0;
      if (!rst) begin
         m_active  = 1'b0;
         m_last_b  = 1'b1;
         m_src     = 1'b0;
         m_wg_data = '0;
         m_busy    = 1'b0;
         m_wg_en   = 1'b1;
         return;
      end
      if (!m_active && (req_a || req_b)) begin
         gb        = req_b && (!req_a || !m_last_b);
         m_active  = 1'b1;
         m_g       = cyc;
         m_last_b  = gb;
         m_src     = gb;
         m_wg_data = wg_frame(gb ? data_b : data_a);
         if (gb) m_ack_b = 1'b1;
         else    m_ack_a = 1'b1;
      end
      m_busy  = 1'b0;
      m_wg_en = 1'b1;
      if (m_active) begin
         r = cyc - m_g;
         if (r < TOTAL) begin
            m_busy  = 1'b1;
            m_wg_en = ((r % FG) < F) ? 1'b0 : 1'b1;
         end else begin
            m_done   = 1'b1;
            m_active = 1'b0;
         end
      end
   endtask

   initial begin
      int          n_ack_a = 0;
      int          n_ack_b = 0;
      int          rst_at  = -1;
      int          rst_len = 0;
      logic        rq [2];
      logic [23:0] dt [2];
      logic        acked [2];
      int          quiet [2];

      m_active = 1'b0;
      m_last_b = 1'b1;
      rq[0] = 1'b0; rq[1] = 1'b0;
      dt[0] = '0;   dt[1] = '0;
      quiet[0] = 0; quiet[1] = 0;

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         model_step();
         check_eq("ack_a",   ack_a,   m_ack_a);
         check_eq("ack_b",   ack_b,   m_ack_b);
         check_eq("done",    done,    m_done);
         check_eq("busy",    busy,    m_busy);
         check_eq("wg_en",   wg_en,   m_wg_en);
         check_eq("wg_data", wg_data, m_wg_data);
         check_eq("src",     src,     m_src);

         if (ack_a) n_ack_a++;
         if (ack_b) n_ack_b++;
         rst = (cyc >= 2);

         if (cyc < 130) begin
            // directed: A alone, then B alone with a reset mid-frame
            if (cyc == 3) begin
               req_a  = 1'b1;
               data_a = 24'h000001;
            end
            if (cyc < 60 && ack_a) begin
               check_eq("kat_a_data", wg_data, 26'h0000002);
               check_eq("kat_a_src", src, 0);
               req_a = 1'b0;
            end
            if (cyc == 59) check_eq("a_served_once", n_ack_a, 1);
            if (cyc == 60) begin
               req_b  = 1'b1;
               data_b = 24'h800000;
            end
            if (cyc >= 60 && ack_b) begin
               if (n_ack_b == 1) begin
                  check_eq("kat_b_data", wg_data, 26'h3000001);
                  check_eq("kat_b_src", src, 1);
                  rst_at = cyc + 10;
               end else begin
                  req_b = 1'b0;
               end
            end
            if (cyc == rst_at) rst = 1'b0;
            if (cyc == 129) begin
               check_eq("b_reacked", n_ack_b, 2);
               check_eq("a_untouched", n_ack_a, 1);
            end
         end else if (cyc < 350) begin
            // both requesters held continuously: service must alternate
            if (cyc == 130) begin
               req_a  = 1'b1;
               req_b  = 1'b1;
               data_a = 24'($urandom);
               data_b = 24'($urandom);
            end
            if (ack_a) data_a = 24'($urandom);
            if (ack_b) data_b = 24'($urandom);
            if (cyc == 349) begin
               check_eq("alternation", (n_ack_a - n_ack_b + 2) / 2, 1);
               req_a = 1'b0;
               req_b = 1'b0;
            end
         end else begin
            acked[0] = ack_a;
            acked[1] = ack_b;
            for (int i = 0; i < 2; i++) begin
               if (rq[i]) begin
                  if (acked[i]) begin
                     rq[i]    = 1'b0;
                     quiet[i] = $urandom_range(0, 40);
                     if (quiet[i] == 0) begin
                        rq[i] = 1'b1;
                        dt[i] = 24'($urandom);
                     end
                  end else if ($urandom_range(0, 63) == 0) begin
                     rq[i]    = 1'b0;
                     quiet[i] = $urandom_range(1, 40);
                  end else if ($urandom_range(0, 15) == 0) begin
                     dt[i] = 24'($urandom);
                  end
               end else if (quiet[i] == 0) begin
                  rq[i] = 1'b1;
                  dt[i] = 24'($urandom);
               end else begin
                  quiet[i]--;
               end
            end
            if (rst_len == 0 && $urandom_range(0, 299) == 0) rst_len = $urandom_range(1, 3);
            if (rst_len > 0) begin
               rst = 1'b0;
               rst_len--;
            end
            req_a  = rq[0];
            data_a = dt[0];
            req_b  = rq[1];
            data_b = dt[1];
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
